// File: rtl/mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_pkg : shared encodings for the SDRAM requester front end
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int DEFAULT_ADDR_W = 21;

  localparam logic [3:0] RS_IDLE       = 4'h0;
  localparam logic [3:0] RS_READ_DONE  = 4'h1;
  localparam logic [3:0] RS_WRITE_DONE = 4'h2;
  localparam logic [3:0] RS_FAULT      = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_RESP = ST_RESP
  } state_e;

  // Anything other than the done code matching the direction is an error.
  function automatic logic status_ok(input logic is_write, input logic [3:0] st);
    return is_write ? (st == RS_WRITE_DONE) : (st == RS_READ_DONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_requester_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_requester_if : host command/response bus plus controller request bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_requester_if #(
  parameter int ADDR_W = mem_pkg::DEFAULT_ADDR_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [15:0]       cmd_wdata;
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              rsp_error;
  logic              ram_request_read;
  logic              ram_request_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;
  logic [3:0]        ram_state;
  logic              ram_event;

  // master: the requester itself; slave: host plus controller around it
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  ram_rdata, ram_state, ram_event,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output ram_request_read, ram_request_write, ram_addr, ram_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output ram_rdata, ram_state, ram_event,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  ram_request_read, ram_request_write, ram_addr, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_requester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_requester : single-outstanding read/write requester for the SDRAM
//                 controller, with completion status check and timeout
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_requester
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = DEFAULT_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_requester_if.master  bus
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_error_q, rsp_error_d;
  logic [15:0]       rsp_rdata_q, rsp_rdata_d;
  logic              req_rd_q, req_rd_d;
  logic              req_wr_q, req_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]       ram_wdata_q, ram_wdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
      req_rd_q    <= req_rd_d;
      req_wr_q    <= req_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;
    req_rd_d    = req_rd_q;
    req_wr_d    = req_wr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          ram_addr_d  = bus.cmd_addr;
          ram_wdata_d = bus.cmd_wdata;
          req_rd_d    = ~bus.cmd_write;
          req_wr_d    = bus.cmd_write;
          cnt_d       = CNT_LOAD;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // The event is checked first so it wins over a simultaneous timeout.
        if (bus.ram_event) begin
          req_rd_d    = 1'b0;
          req_wr_d    = 1'b0;
          rsp_rdata_d = bus.ram_rdata;
          rsp_error_d = ~status_ok(req_wr_q, bus.ram_state);
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == '0) begin
          req_rd_d    = 1'b0;
          req_wr_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  assign bus.cmd_ready         = cmd_ready_q;
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_error         = rsp_error_q;
  assign bus.rsp_rdata         = rsp_rdata_q;
  assign bus.ram_request_read  = req_rd_q;
  assign bus.ram_request_write = req_wr_q;
  assign bus.ram_addr          = ram_addr_q;
  assign bus.ram_wdata         = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_requester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_requester : directed + randomized transactions against a
//                    transaction-level expectation model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_requester;

  localparam int T_CYC = 8;
  localparam int AW    = 21;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_requester_if #(.ADDR_W(AW)) bus ();

  mem_requester #(.TIMEOUT_CYCLES(T_CYC), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One transaction, entered and left on a negedge inside an IDLE cycle.
  // lat = number of cycles the request line is seen high before the event;
  // lat = 0 means the controller never answers.
  task automatic txn(input bit wr, input logic [AW-1:0] addr, input logic [15:0] wd,
                     input int lat, input logic [3:0] st, input logic [15:0] rd,
                     input bit hold);
    bit          tmo;
    int          n;
    logic        exp_err;
    logic [15:0] exp_rd;
    tmo     = (lat == 0);
    n       = tmo ? T_CYC : lat;
    exp_err = tmo || !(wr ? (st == 4'h2) : (st == 4'h1));
    exp_rd  = tmo ? 16'h0000 : rd;

    chk("ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
    chk("ready_busy", bus.cmd_ready, 0);
    for (int k = 1; k <= n; k++) begin
      chk("req_rd", bus.ram_request_read, !wr);
      chk("req_wr", bus.ram_request_write, wr);
      chk("req_excl", bus.ram_request_read & bus.ram_request_write, 0);
      chk("addr", bus.ram_addr, addr);
      chk("wdata", bus.ram_wdata, wd);
      chk("no_early_rsp", bus.rsp_valid, 0);
      if (k == n && !tmo) begin
        bus.ram_event = 1'b1;
        bus.ram_state = st;
        bus.ram_rdata = rd;
      end
      @(negedge clk);
      bus.ram_event = 1'b0;
      bus.ram_rdata = 16'($urandom);
      bus.ram_state = 4'($urandom);
    end
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_error", bus.rsp_error, exp_err);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("req_drop", {bus.ram_request_read, bus.ram_request_write}, 0);
    chk("ready_resp", bus.cmd_ready, 0);
    @(negedge clk);
    chk("rsp_pulse", bus.rsp_valid, 0);
  endtask

  task automatic spurious_event();
    bus.ram_event = 1'b1;
    bus.ram_state = 4'h1;
    @(negedge clk);
    bus.ram_event = 1'b0;
    chk("spur_rsp", bus.rsp_valid, 0);
    @(negedge clk);
    chk("spur_rsp2", bus.rsp_valid, 0);
    chk("spur_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          wr;
    int          lat;
    logic [3:0]  st;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.ram_rdata = '0;
    bus.ram_state = '0;
    bus.ram_event = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_error}, 0);
    chk("rst_req", {bus.ram_request_read, bus.ram_request_write}, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_data", {bus.ram_wdata, bus.rsp_rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    txn(1, 21'h00123, 16'hBEEF, 5, 4'h2, 16'h1111, 0);
    txn(0, 21'h00123, 16'h0000, 3, 4'h1, 16'hBEEF, 0);
    txn(0, 21'h0ABCD, 16'h5555, 0, 4'h1, 16'h7777, 0);
    txn(0, 21'h1FFFF, 16'h0001, 2, 4'hF, 16'hCAFE, 0);
    spurious_event();
    txn(1, 21'h00042, 16'h1234, T_CYC, 4'h2, 16'h0000, 0);
    txn(1, 21'h00043, 16'h4321, 1, 4'h1, 16'h0000, 0);

    // Reset while a read is outstanding
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 21'h15A5A;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("mid_req", bus.ram_request_read, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {bus.ram_request_read, bus.ram_request_write}, 0);
    chk("mid_rst_ready", bus.cmd_ready, 1);
    chk("mid_rst_addr", bus.ram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    spurious_event();

    // Back-to-back alternating write/read, cmd_valid held high
    for (int i = 0; i < 4; i++)
      txn(i % 2 == 0, AW'(21'h00200 + i), 16'hA000 + 16'(i), 2,
          (i % 2 == 0) ? 4'h2 : 4'h1, 16'h5000 + 16'(i), i < 3);
    bus.cmd_valid = 1'b0;

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom);
      lat = $urandom_range(0, T_CYC);
      st  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (wr ? 4'h2 : 4'h1);
      txn(wr, AW'($urandom), 16'($urandom), lat, st, 16'($urandom), 0);
      if ($urandom_range(0, 4) == 0) spurious_event();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
